// File: rtl/core_joypad_pkg.sv
// Shared types and constants for the NES joypad bridge: scanner states and button bit positions.
package core_joypad_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StLatch,
        StSample0,
        StLow,
        StHigh,
        StDone,
        StGap
    } scan_state_e;

    localparam int unsigned NumButtons = 8;

    localparam int unsigned BtnA      = 0;
    localparam int unsigned BtnB      = 1;
    localparam int unsigned BtnSelect = 2;
    localparam int unsigned BtnStart  = 3;
    localparam int unsigned BtnUp     = 4;
    localparam int unsigned BtnDown   = 5;
    localparam int unsigned BtnLeft   = 6;
    localparam int unsigned BtnRight  = 7;

endpackage

// File: rtl/core_joypad_bridge_if.sv
// Core-side emulated joypad port bundle: strobe/clock from the core, serial data back to it.
interface core_joypad_bridge_if;

    logic [2:0] core_controllers_joypad_out;
    logic [1:0] core_controllers_joypad_clock;
    logic [4:0] core_controllers_joypad1_data;
    logic [4:0] core_controllers_joypad2_data;

    modport master (
        output core_controllers_joypad_out,
        output core_controllers_joypad_clock,
        input  core_controllers_joypad1_data,
        input  core_controllers_joypad2_data
    );

    modport slave (
        input  core_controllers_joypad_out,
        input  core_controllers_joypad_clock,
        output core_controllers_joypad1_data,
        output core_controllers_joypad2_data
    );

endinterface

// File: rtl/joypad_shift_port.sv
// Emulated 4021 shift register for one core joypad port: parallel load on strobe, shift on clock rise.
module joypad_shift_port (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       strobe_i,
    input  logic       clock_i,
    input  logic [7:0] buttons_i,
    output logic       data_o
);

    logic       clock_q;
    logic       clk_rise;
    logic [7:0] shift_q, shift_d;
    logic       data_q;

    assign clk_rise = clock_i & ~clock_q;

    // Ones shift in from the top so an over-read port reports 1, like the real part.
    always_comb begin
        shift_d = shift_q;
        if (strobe_i) begin
            shift_d = buttons_i;
        end else if (clk_rise) begin
            shift_d = {1'b1, shift_q[7:1]};
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            clock_q <= 1'b0;
            shift_q <= 8'h00;
            data_q  <= 1'b0;
        end else begin
            clock_q <= clock_i;
            shift_q <= shift_d;
            data_q  <= shift_d[0];
        end
    end

    assign data_o = data_q;

endmodule

// File: rtl/core_joypad_bridge.sv
// Scans two physical NES pads on shared latch/clock pins and serves the bytes to the core's ports.
module core_joypad_bridge
    import core_joypad_pkg::*;
#(
    parameter int unsigned CLK_DIV   = 256,
    parameter int unsigned GAP_TICKS = 64
) (
    input  logic                 core_cpu_clk,
    input  logic                 core_cpu_reset,
    input  logic                 pad1_serial_in,
    input  logic                 pad2_serial_in,
    output logic                 pad_latch_out,
    output logic                 pad_clk_out,
    core_joypad_bridge_if.slave  core,
    output logic [7:0]           pad1_buttons,
    output logic [7:0]           pad2_buttons,
    output logic                 scan_valid
);

    localparam int unsigned DivW  = $clog2(CLK_DIV);
    localparam int unsigned StepW = $clog2(GAP_TICKS + NumButtons);

    localparam logic [DivW-1:0]  DivReload = DivW'(CLK_DIV - 1);
    localparam logic [StepW-1:0] LatchLast = StepW'(1);
    localparam logic [StepW-1:0] BitLast   = StepW'(BtnRight);
    localparam logic [StepW-1:0] GapLast   = StepW'(GAP_TICKS - 1);

    scan_state_e      state_q, state_d;
    logic [DivW-1:0]  div_q, div_d;
    logic [StepW-1:0] step_q, step_d;
    logic [7:0]       shadow1_q, shadow1_d, shadow2_q, shadow2_d;
    logic [7:0]       buttons1_q, buttons2_q;
    logic             scan_valid_q;
    logic             tick;
    logic             port1_data, port2_data;
    logic             unused_joypad_out;

    assign tick = (div_q == '0);
    assign unused_joypad_out = ^core.core_controllers_joypad_out[2:1];

    always_comb begin
        div_d = div_q - 1'b1;
        if (state_q == StDone || tick) begin
            div_d = DivReload;
        end
    end

    // step_q counts latch ticks, the bit index while shifting, and gap ticks.
    always_comb begin
        state_d       = state_q;
        step_d        = step_q;
        shadow1_d     = shadow1_q;
        shadow2_d     = shadow2_q;
        pad_latch_out = 1'b0;
        pad_clk_out   = 1'b1;
        unique case (state_q)
            StIdle: begin
                state_d = StLatch;
                step_d  = '0;
            end
            StLatch: begin
                pad_latch_out = 1'b1;
                if (tick) begin
                    if (step_q == LatchLast) begin
                        state_d = StSample0;
                        step_d  = '0;
                    end else begin
                        step_d = step_q + 1'b1;
                    end
                end
            end
            StSample0: begin
                if (tick) begin
                    shadow1_d[BtnA] = ~pad1_serial_in;
                    shadow2_d[BtnA] = ~pad2_serial_in;
                    state_d         = StLow;
                    step_d          = StepW'(BtnB);
                end
            end
            StLow: begin
                pad_clk_out = 1'b0;
                if (tick) begin
                    state_d = StHigh;
                end
            end
            StHigh: begin
                if (tick) begin
                    shadow1_d[step_q[2:0]] = ~pad1_serial_in;
                    shadow2_d[step_q[2:0]] = ~pad2_serial_in;
                    if (step_q == BitLast) begin
                        state_d = StDone;
                    end else begin
                        state_d = StLow;
                        step_d  = step_q + 1'b1;
                    end
                end
            end
            StDone: begin
                state_d = StGap;
                step_d  = '0;
            end
            StGap: begin
                if (tick) begin
                    if (step_q == GapLast) begin
                        state_d = StLatch;
                        step_d  = '0;
                    end else begin
                        step_d = step_q + 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge core_cpu_clk) begin
        if (core_cpu_reset) begin
            state_q      <= StIdle;
            div_q        <= DivReload;
            step_q       <= '0;
            shadow1_q    <= 8'h00;
            shadow2_q    <= 8'h00;
            buttons1_q   <= 8'h00;
            buttons2_q   <= 8'h00;
            scan_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            div_q        <= div_d;
            step_q       <= step_d;
            shadow1_q    <= shadow1_d;
            shadow2_q    <= shadow2_d;
            scan_valid_q <= (state_q == StDone);
            if (state_q == StDone) begin
                buttons1_q <= shadow1_q;
                buttons2_q <= shadow2_q;
            end
        end
    end

    assign pad1_buttons = buttons1_q;
    assign pad2_buttons = buttons2_q;
    assign scan_valid   = scan_valid_q;

    joypad_shift_port u_port1 (
        .clk_i     (core_cpu_clk),
        .rst_i     (core_cpu_reset),
        .strobe_i  (core.core_controllers_joypad_out[0]),
        .clock_i   (core.core_controllers_joypad_clock[0]),
        .buttons_i (buttons1_q),
        .data_o    (port1_data)
    );

    joypad_shift_port u_port2 (
        .clk_i     (core_cpu_clk),
        .rst_i     (core_cpu_reset),
        .strobe_i  (core.core_controllers_joypad_out[0]),
        .clock_i   (core.core_controllers_joypad_clock[1]),
        .buttons_i (buttons2_q),
        .data_o    (port2_data)
    );

    assign core.core_controllers_joypad1_data = {4'b0000, port1_data};
    assign core.core_controllers_joypad2_data = {4'b0000, port2_data};

endmodule

// File: doc/core_joypad_bridge.md
# core_joypad_bridge

Bridges two physical NES-style controllers onto the core's emulated joypad ports. A scanner FSM clocks both physical pads on shared latch/clock pins and sends each scan's button bytes to two emulated 4021 shift registers. Those registers drive `core_controllers_joypad1_data` / `core_controllers_joypad2_data` in response to the core's `core_controllers_joypad_out` strobe and `core_controllers_joypad_clock` pulses. The block sits directly upstream of the NES core's controller inputs.

## Interface
Parameters:
- `CLK_DIV`, 256: `core_cpu_clk` cycles per scanner tick; minimum 2.
- `GAP_TICKS`, 64: idle ticks between scans; minimum 1.

Ports:
- `core_cpu_clk`  in  1  sole clock.
- `core_cpu_reset`  in  1  synchronous, active-high reset.
- `pad1_serial_in`, `pad2_serial_in`  in  1  physical pad data; active-low (0 = pressed).
- `pad_latch_out`  out  1  shared physical latch.
- `pad_clk_out`  out  1  shared physical clock; idles high.
- `core_controllers_joypad_out`  in  3  bit0 = strobe; bits 2:1 ignored.
- `core_controllers_joypad_clock`  in  2  bit n clocks port n+1; rising edge significant.
- `core_controllers_joypad1_data`, `core_controllers_joypad2_data`  out  5  bit0 = serial bit, 1 = pressed; bits 4:1 constant 0.
- `pad1_buttons`, `pad2_buttons`  out  8  last committed scan {Right,Left,Down,Up,Start,Select,B,A}; A is bit0.
- `scan_valid`  out  1  one-cycle pulse on each commit.

## Operation
- Tick generator:
  - Down-counter reloads to CLK_DIV-1; tick fires when the counter is 0.
  - Counter reloads on reset and on leaving DONE.
- Scanner FSM; every transition except from IDLE and DONE happens on a tick:
  - IDLE: latch 0, clk 1; moves to LATCH on the next cycle.
  - LATCH: latch 1 for 2 ticks.
  - SAMPLE0: latch 0 for 1 tick; at the tick, capture bit0 = ~serial_in for both pads.
  - LOW: clk 0 for 1 tick.
  - HIGH: clk 1 for 1 tick; at the tick, capture bit[i] = ~serial_in. Bit index runs 1..7, then DONE; otherwise back to LOW.
  - DONE: one cycle; copy shadow bytes into `padN_buttons` and pulse `scan_valid`.
  - GAP: GAP_TICKS ticks, then LATCH.
- Scan period is (17+GAP_TICKS)·CLK_DIV + 1 cycles.
- Emulated port (per port n):
  - Edge detect: `clk_rise` = clock[n] & ~clock_q[n].
  - While strobe = 1: `shift <= padN_buttons` every cycle; clock rises are ignored.
  - While strobe = 0 and `clk_rise`: `shift <= {1'b1, shift[7:1]}`. After 8 shifts the port reads 1 indefinitely, matching hardware.
  - `data[0] = shift[0]`, registered.
- A commit while strobe is 0 does not disturb an in-progress read; it is seen at the next strobe.

## Timing
- Reset values:
  - Outputs: `pad_latch_out` 0, `pad_clk_out` 1, `padN_buttons` 0, `scan_valid` 0, both `joypadN_data` 0.
  - Internal: shift registers 0x00, clock_q 0, FSM IDLE.
- Reset mid-scan aborts the scan immediately and discards the shadow bytes. The first LATCH begins 1 cycle after reset deasserts.
- Strobe-to-data latency:
  - The shift register loads on the first strobe-high cycle; `data[0]` reflects the loaded A bit 1 cycle later.
- Commit during strobe high: the shift register holds the old byte on the commit cycle and the new byte from the following cycle.
- Clock-to-data latency: `data[0]` updates on the cycle after the cycle where `clk_rise` is detected. Rises on consecutive cycles each shift.
- Strobe falling and `clk_rise` in the same cycle: the shift happens and operates on the last loaded value.
- Both ports are independent. Simultaneous rises on both ports shift both.

## Structure
- Package `core_joypad_pkg`:
  - Scanner state enum: IDLE, LATCH, SAMPLE0, LOW, HIGH, DONE, GAP.
  - Button bit-index constants: BTN_A=0 … BTN_RIGHT=7.
- Sub-module `joypad_shift_port`, instanced twice. It contains the edge detect, the 8-bit shift register and the registered data bit.
- Top level holds the tick counter, scanner FSM, bit counter and shadow registers.

## Test plan
- Reset: assert reset for 3 cycles mid-LATCH → latch 0, clk 1, buttons 0x00, data 0, scan_valid 0. Deassert → LATCH starts 1 cycle later.
- Physical scan (CLK_DIV=4, GAP_TICKS=2): pad1 drives 0 for bits A and Start, pad2 drives all 1 → `pad1_buttons`=0x09, `pad2_buttons`=0x00. `scan_valid` pulses exactly every 77 cycles.
- Emulated read: buttons 0x09; strobe 1 for 2 cycles, then 0; 10 clock rises on port 1 → `data[0]` sequence 1,0,0,1,0,0,0,0,1,1.
- Clock while strobe high: 5 clock rises with strobe 1, buttons 0x01 → `data[0]` stays 1 and the shift register stays 0x01.
- Commit mid-read: after 3 shifts of 0x09, a new scan commits 0xFF → remaining bits 1,0,0,0,0 unchanged. The next strobe reads 0xFF.
- Port independence: port 2 clocked 4 times, port 1 not → `joypad1_data` still shows A, and port 2 shows bit4 of `pad2_buttons`.
